// File: rtl/text_char_arbiter.sv
// Round-robin arbiter sharing the text_driver_80x60 CHAR/WE port between two sources.
// Optional line lock, enabled by defining TEXT_ARB_LINE_LOCK_EN.
`timescale 1ns/1ps
module text_char_arbiter #(
   parameter int HOLD_CYCLES  = 4,
   parameter int CLEAR_CYCLES = 4800,
   parameter int LOCK_TIMEOUT = 1023
) (
   input  logic       CLK_50MHz,
   input  logic       RESET_N,
   input  logic [7:0] A_CHAR,
   input  logic       A_VALID,
   output logic       A_READY,
   input  logic [7:0] B_CHAR,
   input  logic       B_VALID,
   output logic       B_READY,
   output logic [7:0] CHAR,
   output logic       WE,
   output logic       GRANT,
   output logic       BUSY
);

   localparam int MAX_HOLD = (HOLD_CYCLES > CLEAR_CYCLES) ? HOLD_CYCLES : CLEAR_CYCLES;
   localparam int CNT_W    = ($clog2(MAX_HOLD) < 1) ? 1 : $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [7:0] CH_LF  = 8'd10;
   localparam logic [7:0] CH_DEL = 8'd127;

   if (HOLD_CYCLES < 1 || CLEAR_CYCLES < 1 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_bad_param
      $error("text_char_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_next;
   logic             ptr;       // 0: A has priority on a tie
   logic             elig_a, elig_b;
   logic             winner;
   logic             transfer;
   logic [7:0]       winner_char;

`ifdef TEXT_ARB_LINE_LOCK_EN
   logic        lock, owner;
   logic [15:0] tmo_cnt;
   logic        owner_valid;
   logic        lock_char;

   assign elig_a      = A_VALID && (!lock || !owner);
   assign elig_b      = B_VALID && (!lock ||  owner);
   assign owner_valid = owner ? B_VALID : A_VALID;
   assign lock_char   = (winner_char != CH_LF) && (winner_char != CH_DEL);

   // Any accepted character either opens/continues a line (lock) or ends it.
   always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         lock    <= 1'b0;
         owner   <= 1'b0;
         tmo_cnt <= '0;
      end else if (transfer) begin
         lock    <= lock_char;
         owner   <= winner;
         tmo_cnt <= '0;
      end else if (lock && state == IDLE && !owner_valid) begin
         if (tmo_cnt >= 16'(LOCK_TIMEOUT - 1)) begin
            lock    <= 1'b0;
            tmo_cnt <= '0;
         end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end
      end
   end
`else
   assign elig_a = A_VALID;
   assign elig_b = B_VALID;
`endif

   always_comb begin
      winner = 1'b0;
      if (elig_a && elig_b) winner = ptr;
      else if (elig_b)      winner = 1'b1;
   end

   // READY is forced low while reset is asserted even though the state reads IDLE.
   assign A_READY     = RESET_N && (state == IDLE) && elig_a && !winner;
   assign B_READY     = RESET_N && (state == IDLE) && elig_b &&  winner;
   assign transfer    = A_READY || B_READY;
   assign winner_char = winner ? B_CHAR : A_CHAR;
   assign BUSY        = (state != IDLE);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge CLK_50MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         hold_cnt <= '0;
         ptr      <= 1'b0;
         CHAR     <= 8'd0;
         WE       <= 1'b0;
         GRANT    <= 1'b0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_cnt_next;
         WE       <= transfer;
         if (transfer) begin
            CHAR  <= winner_char;
            GRANT <= winner;
            ptr   <= ~winner;
         end
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_next    = state;
      hold_cnt_next = hold_cnt;
      unique case (state)
         IDLE: begin
            if (transfer) state_next = ISSUE;
         end
         ISSUE: begin
            hold_cnt_next = (CHAR == CH_DEL) ? CLEAR_LOAD : HOLD_LOAD;
            state_next    = HOLD;
         end
         HOLD: begin
            if (hold_cnt == '0) state_next = IDLE;
            else                hold_cnt_next = hold_cnt - CNT_W'(1);
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
